multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32I core (R-type, LW, SW, BEQ). It replaces single-cycle
//  opcode decode with a Moore/Mealy FSM that steps the shared ALU, register file and unified
//  instruction/data memory through fetch/decode/execute/memory/writeback phases.
//  Handshakes with memory via mem_ready; aborts hung accesses with a timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive mem_ready-low cycles in a memory state before abort
//  CNT_W        4   timeout counter width; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk        in   1   core clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  opcode     in   7   instr[6:0] from instruction register
//  zero       in   1   ALU zero flag
//  mem_ready  in   1   memory completes current read/write this cycle
//  PCWrite    out  1   load PC (PC+4 if Branch=0, branch target if Branch=1)
//  IRWrite    out  1   load instruction register from memory read data
//  IorD       out  1   memory address select: 0=PC, 1=ALU result register
//  MemRead    out  1   memory read strobe, held until mem_ready
//  MemWrite   out  1   memory write strobe, held until mem_ready
//  MemtoReg   out  1   writeback select: 0=ALU result, 1=memory data register
//  RegWrite   out  1   register file write enable
//  ALUSrc     out  1   ALU B operand: 0=rs2, 1=immediate
//  ALUOp      out  2   00=add, 01=sub/compare, 10=funct-decoded
//  Branch     out  1   PC source = branch target
//  illegal_op out  1   1-cycle pulse: unsupported opcode in DECODE
//  bus_error  out  1   1-cycle pulse: memory timeout abort
//  state_o    out  4   current state encoding (debug)
//  instret    out  32  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: while rst_n=0 state=IDLE, all outputs 0, op_q=0, timeout counter=0. Reset
//   mid-access abandons the instruction; no strobe is asserted during reset.
//  Unlisted outputs are 0 in every state.
//  IDLE: all 0; goes to FETCH next cycle.
//  FETCH: MemRead=1, IorD=0. On mem_ready: IRWrite=1, PCWrite=1 (Mealy), then DECODE.
//  DECODE: 1 cycle; op_q<=opcode.
//   0110011 -> EXEC_R. 0000011/0100011 -> ADDR. 1100011 -> BRANCH.
//   Else illegal_op=1 -> FETCH, with no register or memory write.
//  EXEC_R: ALUSrc=0, ALUOp=10 -> WB_R.
//  WB_R: RegWrite=1, MemtoReg=0, ALUOp=10 -> FETCH.
//  ADDR: ALUSrc=1, ALUOp=00 -> MEM_RD if op_q=0000011, else MEM_WR.
//  MEM_RD: IorD=1, MemRead=1 until mem_ready -> WB_LD.
//  WB_LD: RegWrite=1, MemtoReg=1 -> FETCH.
//  MEM_WR: IorD=1, MemWrite=1 until mem_ready -> FETCH.
//  BRANCH: ALUSrc=0, ALUOp=01, Branch=1, PCWrite=zero (Mealy) -> FETCH.
//  Latency with zero-wait memory (mem_ready=1 on first cycle), FETCH to next FETCH:
//   R-type 4 cycles, LW 5, SW 4, BEQ 3, illegal 2. Each wait cycle adds 1.
//  Timeout counter: cleared on entry to FETCH/MEM_RD/MEM_WR; +1 per cycle with mem_ready=0.
//   If count==MEM_TIMEOUT and mem_ready=0: bus_error=1 and strobes drop that cycle;
//   next state FETCH with PC not advanced (a fetch timeout retries the same PC).
//   mem_ready=1 on the timeout cycle wins: normal completion, no bus_error.
//   The counter saturates and never wraps.
//  opcode is sampled only in DECODE; later opcode changes are ignored (op_q used).
// CONFIGURATION
//  CTRL_PERF_EN defined:
//   instret is a 32-bit counter reset to 0.
//   +1 on the last cycle of each completed instruction: WB_R, WB_LD, MEM_WR with
//    mem_ready, BRANCH.
//   No increment on illegal_op or bus_error. Wraps 0xFFFFFFFF -> 0.
//  CTRL_PERF_EN undefined: instret tied to 0 and no counter flops.
// TESTING
//  1. Reset pulse mid-MEM_WR with MemWrite=1 -> MemWrite=0 immediately; IDLE, then FETCH
//     1 cycle after rst_n rises.
//  2. R-type (0110011), mem_ready=1 -> IRWrite/PCWrite in cycle 1, RegWrite=1 with
//     ALUOp=10 in cycle 4, FETCH in cycle 5.
//  3. LW with 3 wait cycles in MEM_RD -> MemRead held 4 cycles; WB_LD RegWrite=1,
//     MemtoReg=1; total 8 cycles.
//  4. BEQ with zero=1 -> PCWrite=1, Branch=1 in cycle 3. With zero=0 -> PCWrite=0 in
//     cycle 3. Both return to FETCH.
//  5. opcode=1101111 -> illegal_op pulses in DECODE; no RegWrite/MemWrite; FETCH next cycle.
//  6. SW, mem_ready held 0 -> bus_error in 16th MEM_WR cycle, MemWrite=0 that cycle,
//     then FETCH. Repeat with mem_ready=1 on the 16th cycle -> no bus_error;
//     with CTRL_PERF_EN, instret +1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle control sequencer for an RV32I subset (R-type, LW,
//               SW, BEQ). It steps the shared ALU, register file and unified
//               memory through fetch / decode / execute / memory / writeback.
//               Memory handshakes use mem_ready. A per-access timeout aborts
//               hung accesses with a one-cycle bus_error pulse.
// Ports       : clk, rst_n (async active-low)
//               opcode, zero, mem_ready                  -> inputs
//               PCWrite, IRWrite, IorD, MemRead, MemWrite,
//               MemtoReg, RegWrite, ALUSrc, ALUOp, Branch -> datapath controls
//               illegal_op, bus_error                     -> 1-cycle event pulses
//               state_o (debug), instret (retired count)
// Config      : `define CTRL_PERF_EN enables the 32-bit instret counter;
//               otherwise instret is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        Branch,
    output logic        illegal_op,
    output logic        bus_error,
    output logic [3:0]  state_o,
    output logic [31:0] instret
);

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] cnt_q;

    logic w_mem_state;
    logic w_timeout;

    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready on the final allowed cycle still completes normally.
    assign w_timeout   = w_mem_state && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (w_timeout) state_d = S_FETCH;  // retry same PC
            S_DECODE: begin
                unique case (opcode)
                    c_OP_RTYPE:             state_d = S_EXEC_R;
                    c_OP_LOAD, c_OP_STORE:  state_d = S_ADDR;
                    c_OP_BRANCH:            state_d = S_BRANCH;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_ADDR:   state_d = (op_q == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
                      else if (w_timeout) state_d = S_FETCH;
            S_WB_LD:  state_d = S_FETCH;
            S_MEM_WR: if (mem_ready || w_timeout) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs. FETCH completion, BRANCH PCWrite and the timeout
    // strobe drop depend on same-cycle inputs, so these are Mealy terms
    // decoded from the state register.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = 2'b00;
        Branch     = 1'b0;
        illegal_op = 1'b0;
        bus_error  = w_timeout;
        unique case (state_q)
            S_FETCH: begin
                MemRead = !w_timeout;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                illegal_op = !((opcode == c_OP_RTYPE) || (opcode == c_OP_LOAD) ||
                               (opcode == c_OP_STORE) || (opcode == c_OP_BRANCH));
            end
            S_EXEC_R: ALUOp = 2'b10;
            S_WB_R: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            S_ADDR:   ALUSrc = 1'b1;
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = !w_timeout;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = !w_timeout;
            end
            S_BRANCH: begin
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                PCWrite = zero;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched opcode and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Any state change (or a fetch retry) starts a fresh wait window.
            if ((state_d != state_q) || w_timeout) begin
                cnt_q <= '0;
            end else if (w_mem_state && !mem_ready && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign state_o = state_q;

`ifdef CTRL_PERF_EN
    logic [31:0] instret_q;
    logic        w_retire;

    assign w_retire = (state_q == S_WB_R) || (state_q == S_WB_LD) || (state_q == S_BRANCH) ||
                      ((state_q == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (w_retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Randomized self-checking bench. Each instruction is expanded
//               into an expected per-cycle control trace from the sequencing
//               rules, then replayed against the DUT with matching inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    // Packed control vector layout used by the bench
    localparam logic [12:0] c_PCW = 13'h1000;
    localparam logic [12:0] c_IRW = 13'h0800;
    localparam logic [12:0] c_IOD = 13'h0400;
    localparam logic [12:0] c_MR  = 13'h0200;
    localparam logic [12:0] c_MW  = 13'h0100;
    localparam logic [12:0] c_M2R = 13'h0080;
    localparam logic [12:0] c_RW  = 13'h0040;
    localparam logic [12:0] c_AS  = 13'h0020;
    localparam logic [12:0] c_FUN = 13'h0010;   // ALUOp = 10
    localparam logic [12:0] c_SUB = 13'h0008;   // ALUOp = 01
    localparam logic [12:0] c_BR  = 13'h0004;
    localparam logic [12:0] c_ILL = 13'h0002;
    localparam logic [12:0] c_BE  = 13'h0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite;
    logic        ALUSrc, Branch, illegal_op, bus_error;
    logic [1:0]  ALUOp;
    logic [3:0]  state_o;
    logic [31:0] instret;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .Branch(Branch), .illegal_op(illegal_op), .bus_error(bus_error),
        .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    wire [12:0] w_ctrl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                          ALUSrc, ALUOp, Branch, illegal_op, bus_error};

    typedef struct {
        logic [12:0] exp;
        logic        rdy;
        logic        z;
        logic [6:0]  opc;
    } cyc_t;

    cyc_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned retired = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef CTRL_PERF_EN
        return retired;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input logic [12:0] e, input logic r, input logic z);
        cyc_t c;
        c.exp = e; c.rdy = r; c.z = z; c.opc = 7'($urandom);
        q.push_back(c);
    endtask

    // A memory phase: `waits` not-ready cycles then completion, or a timeout
    // (16th consecutive not-ready cycle) when waits >= 16.
    task automatic mem_phase(input logic [12:0] strobe, input logic [12:0] done,
                             input int waits, output bit aborted);
        aborted = (waits >= 16);
        if (aborted) begin
            for (int i = 0; i < 15; i++) push(strobe, 1'b0, 1'($urandom));
            push((strobe & ~(c_MR | c_MW)) | c_BE, 1'b0, 1'($urandom));
        end else begin
            for (int i = 0; i < waits; i++) push(strobe, 1'b0, 1'($urandom));
            push(strobe | done, 1'b1, 1'($urandom));
        end
    endtask

    // kind: 0=R, 1=LW, 2=SW, 3=BEQ, 4=illegal. Returns whether it retires.
    task automatic build(input int kind, input int fw, input int mw, input bit z,
                         output bit retires);
        bit   ab;
        logic [6:0] opc;
        retires = 1'b0;
        q.delete();
        mem_phase(c_MR, c_IRW | c_PCW, fw, ab);
        if (ab) return;
        case (kind)
            0: opc = 7'b0110011;
            1: opc = 7'b0000011;
            2: opc = 7'b0100011;
            3: opc = 7'b1100011;
            default: begin
                do opc = 7'($urandom);
                while (opc == 7'b0110011 || opc == 7'b0000011 ||
                       opc == 7'b0100011 || opc == 7'b1100011);
            end
        endcase
        push((kind == 4) ? c_ILL : 13'h0, 1'($urandom), 1'($urandom));
        q[q.size()-1].opc = opc;
        case (kind)
            0: begin
                push(c_FUN, 1'($urandom), 1'($urandom));
                push(c_RW | c_FUN, 1'($urandom), 1'($urandom));
                retires = 1'b1;
            end
            1: begin
                push(c_AS, 1'($urandom), 1'($urandom));
                mem_phase(c_IOD | c_MR, 13'h0, mw, ab);
                if (!ab) begin
                    push(c_RW | c_M2R, 1'($urandom), 1'($urandom));
                    retires = 1'b1;
                end
            end
            2: begin
                push(c_AS, 1'($urandom), 1'($urandom));
                mem_phase(c_IOD | c_MW, 13'h0, mw, ab);
                retires = !ab;
            end
            3: begin
                push(c_SUB | c_BR | (z ? c_PCW : 13'h0), 1'($urandom), z);
                retires = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic run_cycle(input cyc_t c, input string tag);
        @(negedge clk);
        mem_ready = c.rdy;
        zero      = c.z;
        opcode    = c.opc;
        #1;
        check(tag, {19'h0, w_ctrl}, {19'h0, c.exp});
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return $urandom_range(0, 3);
        if (r < 17) return 15;
        return 16;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ret;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {19'h0, w_ctrl}, 32'h0);
        check("reset_instret", instret, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ctrl", {19'h0, w_ctrl}, 32'h0);

        // Directed: R-type, LW with 3 waits, BEQ taken/not, illegal, SW timeout
        // and SW completing on the final allowed cycle; then random mix.
        for (int n = 0; n < 306; n++) begin
            int kind, fw, mw;
            bit z;
            case (n)
                0: begin kind = 0; fw = 0;  mw = 0;  z = 0; end
                1: begin kind = 1; fw = 0;  mw = 3;  z = 0; end
                2: begin kind = 3; fw = 0;  mw = 0;  z = 1; end
                3: begin kind = 3; fw = 0;  mw = 0;  z = 0; end
                4: begin kind = 4; fw = 0;  mw = 0;  z = 0; end
                5: begin kind = 2; fw = 0;  mw = 16; z = 0; end
                default: begin
                    kind = (n == 6) ? 2 : $urandom_range(0, 4);
                    fw   = (n == 6) ? 0 : pick_wait();
                    mw   = (n == 6) ? 15 : pick_wait();
                    z    = 1'($urandom);
                end
            endcase
            build(kind, fw, mw, z, ret);
            foreach (q[i]) run_cycle(q[i], $sformatf("ctrl_k%0d_c%0d", kind, i));
            if (ret) retired++;
            @(posedge clk);
            #1;
            check("instret", instret, exp_instret());
        end

        // Reset in the middle of a store with MemWrite asserted
        build(2, 0, 5, 1'b0, ret);
        for (int i = 0; i < 4; i++) run_cycle(q[i], "pre_rst");
        check("memwrite_before_rst", {31'h0, MemWrite}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_ctrl_async", {19'h0, w_ctrl}, 32'h0);
        retired = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_idle", {19'h0, w_ctrl}, 32'h0);
        check("rst_instret", instret, 32'h0);
        @(posedge clk);
        #1;
        check("rst_fetch", {19'h0, w_ctrl}, {19'h0, c_MR});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
